jtag_tap_driver: RTL and testbench

- Initiator-side sequencer for the virtual JTAG TAP interface; sits in the clk_50_ domain.
- Takes one DR-access command (IR value, bit length, shift data) and produces tck, tdi, ir, capture_dr, shift_dr, exit1_dr and update_dr in the order the TAP-side logic expects.
- Samples tdo into a response word.
- Serves as the board-side driver for loopback/bring-up of the txrxmem user logic and as the bench stimulus generator replacing hand-timed sequences.

---
 rtl/jtag_tap_driver.sv | 202 ++++++++++++++++++++
 tb/tb_jtag_tap_driver.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_driver.sv
// jtag_tap_driver: initiator-side sequencer for the virtual JTAG TAP.
// Runs one DR access per command: loads the instruction, walks the TAP
// through capture/shift/exit1/update on a divided tck, and returns the
// tdo bits sampled during the shift as a response word.
module jtag_tap_driver #(
  parameter int IR_LEN   = 4,
  parameter int DR_MAX   = 64,
  parameter int TCK_HALF = 2
) (
  input  logic              clk_50_,
  input  logic              rstn_,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [IR_LEN-1:0] cmd_ir,
  input  logic [6:0]        cmd_len,
  input  logic [DR_MAX-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DR_MAX-1:0] rsp_data,
  output logic              tck,
  output logic              tdi,
  input  logic              tdo,
  output logic [IR_LEN-1:0] ir,
  output logic              capture_dr,
  output logic              shift_dr,
  output logic              exit1_dr,
  output logic              update_dr
);

  localparam int CNT_W = (TCK_HALF > 1) ? $clog2(TCK_HALF) : 1;
  localparam int IDX_W = (DR_MAX > 1) ? $clog2(DR_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(TCK_HALF - 1);
  localparam logic [6:0]       LEN_MAX = 7'(DR_MAX);

  typedef enum logic [2:0] {
    ST_IDLE, ST_WAIT, ST_SETIR, ST_CAPTURE,
    ST_SHIFT, ST_EXIT1, ST_UPDATE, ST_RESP
  } state_t;

  state_t            state_r;
  logic [CNT_W-1:0]  div_cnt_r;
  logic              tck_r;
  logic              tdi_r;
  logic [IR_LEN-1:0] ir_r;
  logic [IR_LEN-1:0] ir_lat_r;
  logic [DR_MAX-1:0] data_r;
  logic [DR_MAX-1:0] rsp_data_r;
  logic [6:0]        len_r;
  logic [6:0]        bit_idx_r;
  logic              cmd_ready_r;
  logic              rsp_valid_r;
  logic              capture_r;
  logic              shift_r;
  logic              exit1_r;
  logic              update_r;

  logic              term_s;
  logic              fall_ev_s;
  logic              rise_ev_s;
  logic [6:0]        len_clamp_s;

  // Terminal count of the divider marks the edge where tck toggles.
  assign term_s      = (div_cnt_r == CNT_TC);
  assign fall_ev_s   = term_s & tck_r;
  assign rise_ev_s   = term_s & ~tck_r;
  // Over-long requests are clamped to the register width, not rejected.
  assign len_clamp_s = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;

  // Free-running tck divider; keeps toggling even while idle.
  always_ff @(posedge clk_50_) begin
    if (!rstn_) begin
      div_cnt_r <= {CNT_W{1'b0}};
      tck_r     <= 1'b0;
    end else if (term_s) begin
      div_cnt_r <= {CNT_W{1'b0}};
      tck_r     <= ~tck_r;
    end else begin
      div_cnt_r <= div_cnt_r + CNT_W'(1);
    end
  end

  // Access sequencer: TAP-side outputs move on tck fall, tdo sampled on rise.
  always_ff @(posedge clk_50_) begin
    if (!rstn_) begin
      state_r     <= ST_IDLE;
      tdi_r       <= 1'b0;
      ir_r        <= {IR_LEN{1'b0}};
      ir_lat_r    <= {IR_LEN{1'b0}};
      data_r      <= {DR_MAX{1'b0}};
      rsp_data_r  <= {DR_MAX{1'b0}};
      len_r       <= 7'd0;
      bit_idx_r   <= 7'd0;
      cmd_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      capture_r   <= 1'b0;
      shift_r     <= 1'b0;
      exit1_r     <= 1'b0;
      update_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready_r) begin
            ir_lat_r    <= cmd_ir;
            data_r      <= cmd_data;
            len_r       <= len_clamp_s;
            rsp_data_r  <= {DR_MAX{1'b0}};
            cmd_ready_r <= 1'b0;
            state_r     <= ST_WAIT;
          end else begin
            cmd_ready_r <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (fall_ev_s) begin
            ir_r    <= ir_lat_r;
            state_r <= ST_SETIR;
          end
        end
        ST_SETIR: begin
          if (fall_ev_s) begin
            capture_r <= 1'b1;
            state_r   <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (fall_ev_s) begin
            capture_r <= 1'b0;
            if (len_r != 7'd0) begin
              shift_r   <= 1'b1;
              tdi_r     <= data_r[0];
              data_r    <= {1'b0, data_r[DR_MAX-1:1]};
              bit_idx_r <= 7'd0;
              state_r   <= ST_SHIFT;
            end else begin
              exit1_r <= 1'b1;
              state_r <= ST_EXIT1;
            end
          end
        end
        ST_SHIFT: begin
          if (rise_ev_s) begin
            rsp_data_r[bit_idx_r[IDX_W-1:0]] <= tdo;
          end else if (fall_ev_s) begin
            if (bit_idx_r == (len_r - 7'd1)) begin
              shift_r <= 1'b0;
              tdi_r   <= 1'b0;
              exit1_r <= 1'b1;
              state_r <= ST_EXIT1;
            end else begin
              bit_idx_r <= bit_idx_r + 7'd1;
              tdi_r     <= data_r[0];
              data_r    <= {1'b0, data_r[DR_MAX-1:1]};
            end
          end
        end
        ST_EXIT1: begin
          if (fall_ev_s) begin
            exit1_r  <= 1'b0;
            update_r <= 1'b1;
            state_r  <= ST_UPDATE;
          end
        end
        ST_UPDATE: begin
          if (fall_ev_s) begin
            update_r    <= 1'b0;
            rsp_valid_r <= 1'b1;
            state_r     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            cmd_ready_r <= 1'b1;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          tdi_r       <= 1'b0;
          cmd_ready_r <= 1'b0;
          rsp_valid_r <= 1'b0;
          capture_r   <= 1'b0;
          shift_r     <= 1'b0;
          exit1_r     <= 1'b0;
          update_r    <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready  = cmd_ready_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_data   = rsp_data_r;
  assign tck        = tck_r;
  assign tdi        = tdi_r;
  assign ir         = ir_r;
  assign capture_dr = capture_r;
  assign shift_dr   = shift_r;
  assign exit1_dr   = exit1_r;
  assign update_dr  = update_r;

endmodule

// File: tb/tb_jtag_tap_driver.sv
// Bench for jtag_tap_driver: a cycle-indexed model predicts every output
// on every clock, and directed scenarios pin the model with literal values.
module tb_jtag_tap_driver;
  localparam int IR_LEN   = 4;
  localparam int DR_MAX   = 64;
  localparam int TCK_HALF = 2;
  localparam int PER      = 2 * TCK_HALF;

  logic        clk_50_   = 1'b0;
  logic        rstn_     = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        rsp_ready = 1'b0;
  logic [3:0]  cmd_ir    = 4'd0;
  logic [6:0]  cmd_len   = 7'd0;
  logic [63:0] cmd_data  = 64'd0;
  logic        cmd_ready, rsp_valid, tck, tdi, tdo;
  logic [63:0] rsp_data;
  logic [3:0]  ir;
  logic        capture_dr, shift_dr, exit1_dr, update_dr;
  logic        loop_mode = 1'b1;
  logic        tdo_const = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  assign tdo = loop_mode ? tdi : tdo_const;

  jtag_tap_driver #(.IR_LEN(IR_LEN), .DR_MAX(DR_MAX), .TCK_HALF(TCK_HALF)) dut (
    .clk_50_(clk_50_), .rstn_(rstn_), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ir(cmd_ir), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .tck(tck), .tdi(tdi), .tdo(tdo), .ir(ir),
    .capture_dr(capture_dr), .shift_dr(shift_dr), .exit1_dr(exit1_dr), .update_dr(update_dr)
  );

  always #5 clk_50_ = ~clk_50_;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] low_mask(input int len);
    logic [63:0] m;
    m = 64'd0;
    for (int i = 0; i < len; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Model state: n = clk edges since reset release.
  int          m_n     = 0;
  int          m_phase = 0;   // 0 idle, 1 access running, 2 response held
  int          m_f0    = 0;   // edge index of first tck fall after accept
  int          m_len   = 0;
  bit          m_rdy   = 1'b0;
  logic [3:0]  m_ir    = 4'd0;
  logic [3:0]  m_cur_ir = 4'd0;
  logic [63:0] m_data  = 64'd0;
  logic [63:0] m_rsp   = 64'd0;

  // Model + compare: at each falling clk edge, account for the rising edge
  // just taken (inputs are stable across it) and check every output.
  initial begin : model_cmp
    int  p;
    bit  e_cap, e_sh, e_ex, e_up, e_tdi, e_tck;
    forever begin
      @(negedge clk_50_);
      if (!rstn_) begin
        m_n = 0; m_phase = 0; m_rdy = 1'b0; m_cur_ir = 4'd0;
      end else begin
        m_n++;
        case (m_phase)
          0: begin
            if (m_rdy && cmd_valid) begin
              m_phase = 1;
              m_rdy   = 1'b0;
              m_len   = (int'(cmd_len) > DR_MAX) ? DR_MAX : int'(cmd_len);
              m_data  = cmd_data;
              m_ir    = cmd_ir;
              m_f0    = (m_n / PER + 1) * PER;
              m_rsp   = loop_mode ? (m_data & low_mask(m_len))
                                  : (tdo_const ? low_mask(m_len) : 64'd0);
            end else begin
              m_rdy = 1'b1;
            end
          end
          1: if (m_n == m_f0 + (m_len + 4) * PER) m_phase = 2;
          default: if (rsp_ready) begin m_phase = 0; m_rdy = 1'b1; end
        endcase
        if (m_phase == 1 && m_n >= m_f0) m_cur_ir = m_ir;
      end
      p     = (m_phase == 1 && m_n >= m_f0) ? (m_n - m_f0) / PER : -1;
      e_tck = ((m_n / TCK_HALF) % 2) == 1;
      e_cap = (p == 1);
      e_sh  = (p >= 2) && (p < 2 + m_len);
      e_ex  = (p >= 0) && (p == 2 + m_len);
      e_up  = (p >= 0) && (p == 3 + m_len);
      e_tdi = e_sh ? m_data[p - 2] : 1'b0;
      chk("tck",        64'(tck),        64'(e_tck));
      chk("cmd_ready",  64'(cmd_ready),  64'(m_rdy));
      chk("ir",         64'(ir),         64'(m_cur_ir));
      chk("capture_dr", 64'(capture_dr), 64'(e_cap));
      chk("shift_dr",   64'(shift_dr),   64'(e_sh));
      chk("exit1_dr",   64'(exit1_dr),   64'(e_ex));
      chk("update_dr",  64'(update_dr),  64'(e_up));
      chk("tdi",        64'(tdi),        64'(e_tdi));
      chk("rsp_valid",  64'(rsp_valid),  64'(m_phase == 2));
      if (m_phase == 2) chk("rsp_data", rsp_data, m_rsp);
      else if (!rstn_)  chk("rsp_data_rst", rsp_data, 64'd0);
    end
  end

  task automatic tick();
    @(negedge clk_50_);
    #1;
  endtask

  task automatic send(input logic [3:0] i_ir, input logic [6:0] i_len, input logic [63:0] i_data);
    int k;
    k = 0;
    while (!cmd_ready && k < 200) begin tick(); k++; end
    if (k >= 200) chk("cmd_ready_timeout", 64'(cmd_ready), 64'd1);
    cmd_ir = i_ir; cmd_len = i_len; cmd_data = i_data; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Follows one access until rsp_valid, measuring strobe widths and tdi bits.
  task automatic collect(output int f2r, output int sh, output int cap, output int ex,
                         output int up, output logic [63:0] tvec);
    bit prev, started, done;
    int c;
    prev = tck; started = 1'b0; done = 1'b0; c = 0;
    f2r = -1; sh = 0; cap = 0; ex = 0; up = 0; tvec = 64'd0;
    for (int i = 0; i < 3000 && !done; i++) begin
      tick();
      if (!started && prev && !tck) begin started = 1'b1; c = 0; end
      else if (started) c++;
      prev = tck;
      if (shift_dr) begin
        if ((sh % PER) == 0 && (sh / PER) < 64) tvec[sh / PER] = tdi;
        sh++;
      end
      if (capture_dr) cap++;
      if (exit1_dr)   ex++;
      if (update_dr)  up++;
      if (rsp_valid) begin done = 1'b1; f2r = c; end
    end
    if (!done) chk("rsp_valid_timeout", 64'(rsp_valid), 64'd1);
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int f2r, sh, cap, ex, up, hi, k;
    logic [63:0] tvec;
    // Reset and idle behaviour.
    rstn_ = 1'b0;
    repeat (3) tick();
    chk("reset_cmd_ready", 64'(cmd_ready), 64'd0);
    rstn_ = 1'b1;
    tick();
    chk("ready_after_release", 64'(cmd_ready), 64'd1);
    hi = 0;
    for (int i = 0; i < 8; i++) begin tick(); hi += int'(tck); end
    chk("idle_tck_duty", 64'(hi), 64'd4);
    chk("idle_ir", 64'(ir), 64'h0);
    chk("idle_strobes", 64'({capture_dr, shift_dr, exit1_dr, update_dr}), 64'h0);

    // 8-bit loopback access.
    loop_mode = 1'b1;
    send(4'h1, 7'd8, 64'hA5);
    collect(f2r, sh, cap, ex, up, tvec);
    chk("a5_fall_to_rsp", 64'(f2r), 64'd48);
    chk("a5_shift_cycles", 64'(sh), 64'd32);
    chk("a5_tdi_seq", tvec, 64'hA5);
    chk("a5_rsp_data", rsp_data, 64'hA5);
    chk("a5_ir", 64'(ir), 64'h1);
    handshake();

    // Zero-length access.
    send(4'h3, 7'd0, 64'hDEAD_BEEF_0123_4567);
    collect(f2r, sh, cap, ex, up, tvec);
    chk("len0_shift", 64'(sh), 64'd0);
    chk("len0_capture", 64'(cap), 64'd4);
    chk("len0_exit1", 64'(ex), 64'd4);
    chk("len0_update", 64'(up), 64'd4);
    chk("len0_rsp", rsp_data, 64'd0);
    chk("len0_fall_to_rsp", 64'(f2r), 64'd16);
    handshake();

    // Over-long access clamps to 64 bits.
    loop_mode = 1'b0; tdo_const = 1'b1;
    send(4'h2, 7'd100, 64'hFFFF_FFFF_FFFF_FFFF);
    collect(f2r, sh, cap, ex, up, tvec);
    chk("clamp_shift_cycles", 64'(sh), 64'd256);
    chk("clamp_rsp", rsp_data, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("clamp_fall_to_rsp", 64'(f2r), 64'd272);
    handshake();

    // Response held; a second command during the hold is ignored.
    loop_mode = 1'b1; tdo_const = 1'b0;
    send(4'h5, 7'd4, 64'h6);
    collect(f2r, sh, cap, ex, up, tvec);
    for (int i = 0; i < 20; i++) begin
      if (i == 10) begin
        cmd_ir = 4'hC; cmd_len = 7'd2; cmd_data = 64'h3; cmd_valid = 1'b1;
      end else begin
        cmd_valid = 1'b0;
      end
      tick();
      chk("hold_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("hold_rsp_data", rsp_data, 64'h6);
      chk("hold_cmd_ready", 64'(cmd_ready), 64'd0);
    end
    cmd_valid = 1'b0;
    chk("hold_ir_kept", 64'(ir), 64'h5);
    handshake();
    chk("ready_after_hs", 64'(cmd_ready), 64'd1);
    send(4'hC, 7'd2, 64'h3);
    collect(f2r, sh, cap, ex, up, tvec);
    chk("second_rsp", rsp_data, 64'h3);
    chk("second_ir", 64'(ir), 64'hC);
    handshake();

    // Reset during bit 3 of a 16-bit shift.
    send(4'h7, 7'd16, 64'hBEEF);
    k = 0;
    while (!shift_dr && k < 100) begin tick(); k++; end
    chk("reach_shift", 64'(shift_dr), 64'd1);
    repeat (3 * PER) tick();
    rstn_ = 1'b0;
    tick();
    chk("abort_tck", 64'(tck), 64'd0);
    chk("abort_tdi", 64'(tdi), 64'd0);
    chk("abort_ir", 64'(ir), 64'h0);
    chk("abort_strobes", 64'({capture_dr, shift_dr, exit1_dr, update_dr}), 64'h0);
    chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("abort_rsp_data", rsp_data, 64'd0);
    chk("abort_cmd_ready", 64'(cmd_ready), 64'd0);
    tick();
    rstn_ = 1'b1;
    send(4'h9, 7'd4, 64'h9);
    collect(f2r, sh, cap, ex, up, tvec);
    chk("post_reset_rsp", rsp_data, 64'h9);
    chk("post_reset_fall_to_rsp", 64'(f2r), 64'd32);
    handshake();
    repeat (8) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
